// File: rtl/sram_rw_arbiter_pkg.sv
// Shared constants for the two-requester SRAM arbiter: requester indices,
// requester count and a small index-to-onehot helper.
package sram_rw_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int REQ_A   = 0;
  localparam int REQ_B   = 1;

  function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/sram_rr_grant.sv
// Two-way round-robin grant: combinational ready plus the lastGrant register.
// On contention the requester that was not granted most recently wins.
module sram_rr_grant
  import sram_rw_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] valid_i,
  output logic [NUM_REQ-1:0] ready_o,
  output logic               grant_idx_o
);

  logic last_grant_q, last_grant_d;

  always_comb begin
    ready_o     = '0;
    grant_idx_o = 1'b0;
    if (!rst) begin
      if (valid_i[REQ_A] && valid_i[REQ_B]) begin
        grant_idx_o = ~last_grant_q;
      end else if (valid_i[REQ_B]) begin
        grant_idx_o = 1'b1;
      end
      if (|valid_i) begin
        ready_o = req_onehot(grant_idx_o);
      end
    end
  end

  assign last_grant_d = (|ready_o) ? grant_idx_o : last_grant_q;

  // Resetting to B hands A the first contended grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'(REQ_B);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sram_rw_arbiter.sv
// Arbitrates two command streams onto one single-port SRAM: grant, registered
// command stage (N+1) and response stage aligned with SRAM read data (N+2).
module sram_rw_arbiter
  import sram_rw_arbiter_pkg::*;
#(
  parameter int BYTE_COUNT   = 4,
  parameter int ADDRESS_SIZE = 9
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                reqValid,
  output logic [NUM_REQ-1:0]                reqReady,
  input  logic [NUM_REQ-1:0]                reqWriteEnable,
  input  logic [NUM_REQ*BYTE_COUNT-1:0]     reqWriteMask,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0]   reqAddress,
  input  logic [NUM_REQ*8*BYTE_COUNT-1:0]   reqDataWrite,
  output logic [NUM_REQ-1:0]                respValid,
  output logic [8*BYTE_COUNT-1:0]           respData,
  output logic                              primarySelect,
  output logic                              primaryWriteEnable,
  output logic [BYTE_COUNT-1:0]             primaryWriteMask,
  output logic [ADDRESS_SIZE-1:0]           primaryAddress,
  output logic [8*BYTE_COUNT-1:0]           primaryDataWrite,
  input  logic [8*BYTE_COUNT-1:0]           primaryDataRead
);

  localparam int WORD_SIZE = 8 * BYTE_COUNT;

  logic                    grant_idx;
  logic                    xfer;
  logic                    g_we;
  logic [BYTE_COUNT-1:0]   g_mask;
  logic [ADDRESS_SIZE-1:0] g_addr;
  logic [WORD_SIZE-1:0]    g_data;

  logic                    sel_q, sel_d;
  logic                    we_q, we_d;
  logic [BYTE_COUNT-1:0]   mask_q, mask_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]    data_q, data_d;
  logic                    cmd_req_q, cmd_req_d;
  logic [NUM_REQ-1:0]      rv_q, rv_d;
  logic                    rd_read_q, rd_read_d;

  sram_rr_grant u_grant (
    .clk         (clk),
    .rst         (rst),
    .valid_i     (reqValid),
    .ready_o     (reqReady),
    .grant_idx_o (grant_idx)
  );

  assign xfer = |reqReady;

  always_comb begin
    g_we   = reqWriteEnable[REQ_A];
    g_mask = reqWriteMask[BYTE_COUNT-1:0];
    g_addr = reqAddress[ADDRESS_SIZE-1:0];
    g_data = reqDataWrite[WORD_SIZE-1:0];
    if (grant_idx) begin
      g_we   = reqWriteEnable[REQ_B];
      g_mask = reqWriteMask[2*BYTE_COUNT-1:BYTE_COUNT];
      g_addr = reqAddress[2*ADDRESS_SIZE-1:ADDRESS_SIZE];
      g_data = reqDataWrite[2*WORD_SIZE-1:WORD_SIZE];
    end
  end

  // SRAM-facing fields hold their last value while idle; only select drops.
  always_comb begin
    sel_d     = xfer;
    we_d      = xfer ? g_we      : we_q;
    mask_d    = xfer ? g_mask    : mask_q;
    addr_d    = xfer ? g_addr    : addr_q;
    data_d    = xfer ? g_data    : data_q;
    cmd_req_d = xfer ? grant_idx : cmd_req_q;
    rv_d      = sel_q ? req_onehot(cmd_req_q) : '0;
    rd_read_d = sel_q & ~we_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q     <= 1'b0;
      we_q      <= 1'b0;
      mask_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      cmd_req_q <= 1'b0;
      rv_q      <= '0;
      rd_read_q <= 1'b0;
    end else begin
      sel_q     <= sel_d;
      we_q      <= we_d;
      mask_q    <= mask_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      cmd_req_q <= cmd_req_d;
      rv_q      <= rv_d;
      rd_read_q <= rd_read_d;
    end
  end

  assign primarySelect      = sel_q;
  assign primaryWriteEnable = we_q;
  assign primaryWriteMask   = mask_q;
  assign primaryAddress     = addr_q;
  assign primaryDataWrite   = data_q;
  assign respValid          = rv_q;
  // SRAM read data arrives in the response cycle itself, so it is passed through.
  assign respData           = rd_read_q ? primaryDataRead : '0;

endmodule
